f1_start_ctrl: RTL and testbench

F1_START_CTRL -- requirements
Module: f1_start_ctrl

---
 rtl/f1_start_ctrl.sv | 156 +++++++++++++++
 tb/tb_f1_start_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/f1_start_ctrl.sv
// F1 start-light controller: paces the light FSM, holds a random all-lights-on delay, then signals lights out.
// Optional reaction timer is built when F1_REACTION_TIMER_EN is defined.
module f1_start_ctrl #(
  parameter int PRE_W    = 16,
  parameter int DLY_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  input  logic [PRE_W-1:0]    n,
  input  logic                cmd_seq,
  input  logic                cmd_delay,
`ifdef F1_REACTION_TIMER_EN
  input  logic                react_btn,
  output logic [15:0]         react_time,
  output logic                react_valid,
`endif
  output logic                fsm_en,
  output logic                fsm_trigger,
  output logic                busy,
  output logic                lights_out,
  output logic [DLY_BITS:0]   delay_ticks
);

  localparam int DW = DLY_BITS + 1;

  typedef enum logic [1:0] {IDLE, SEQ, DELAY, REARM} state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [DW-1:0]      dticks_q, dticks_d;
  logic [6:0]         lfsr_q;
  logic               trig_q;
  logic               tick, trig_rise;
  logic               en_c, ftrig_c, lo_c;
  logic [DW-1:0]      rand_dly;

  assign tick      = (presc_q == '0);
  assign trig_rise = trigger & ~trig_q;
  assign rand_dly  = {1'b0, lfsr_q[DLY_BITS-1:0]} + DW'(1);

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    dcnt_d   = dcnt_q;
    dticks_d = dticks_q;
    en_c     = 1'b0;
    ftrig_c  = 1'b0;
    lo_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_rise) begin
          ftrig_c = 1'b1;
          en_c    = 1'b1;
          presc_d = n;
          state_d = SEQ;
        end
      end
      SEQ: begin
        // All-lights-on wins over a coincident tick so the light FSM is not advanced past it.
        if (cmd_delay && !cmd_seq) begin
          state_d  = DELAY;
          presc_d  = n;
          dticks_d = rand_dly;
          dcnt_d   = rand_dly;
        end else if (tick) begin
          en_c    = 1'b1;
          presc_d = n;
        end else begin
          presc_d = presc_q - PRE_W'(1);
        end
      end
      DELAY: begin
        if (tick) begin
          presc_d = n;
          if (dcnt_q <= DW'(1)) begin
            en_c    = 1'b1;
            lo_c    = 1'b1;
            state_d = REARM;
          end else begin
            dcnt_d = dcnt_q - DW'(1);
          end
        end else begin
          presc_d = presc_q - PRE_W'(1);
        end
      end
      REARM: begin
        if (!trigger) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      dcnt_q   <= '0;
      dticks_q <= '0;
      lfsr_q   <= 7'h01;
      trig_q   <= 1'b1;  // a trigger held through reset must not look like a rise
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      dcnt_q   <= dcnt_d;
      dticks_q <= dticks_d;
      lfsr_q   <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
      trig_q   <= trigger;
    end
  end

  assign fsm_en      = en_c & ~rst;
  assign fsm_trigger = ftrig_c & ~rst;
  assign lights_out  = lo_c & ~rst;
  assign busy        = (state_q != IDLE) & ~rst;
  assign delay_ticks = dticks_q;

`ifdef F1_REACTION_TIMER_EN
  logic        btn_q, running;
  logic [15:0] rcnt, rcnt_inc;

  assign rcnt_inc = (rcnt == 16'hFFFF) ? rcnt : rcnt + 16'd1;

  // The latched value is rcnt_inc so a press k cycles after lights_out reads back as k.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q       <= 1'b1;
      running     <= 1'b0;
      rcnt        <= '0;
      react_time  <= '0;
      react_valid <= 1'b0;
    end else begin
      btn_q <= react_btn;
      if (ftrig_c) begin
        running     <= 1'b0;
        react_valid <= 1'b0;
      end else if (lo_c) begin
        rcnt    <= '0;
        running <= 1'b1;
      end else if (running) begin
        if (react_btn && !btn_q) begin
          running     <= 1'b0;
          react_time  <= rcnt_inc;
          react_valid <= 1'b1;
        end else begin
          rcnt <= rcnt_inc;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Scoreboard bench for f1_start_ctrl: a light-FSM model closes the loop; expected pulses are queued per start.
module tb_f1_start_ctrl;

  logic        clk = 1'b0;
  logic        rst, trigger;
  logic [15:0] n;
  logic        cmd_seq, cmd_delay;
  logic        fsm_en, fsm_trigger, busy, lights_out;
  logic [4:0]  delay_ticks;
`ifdef F1_REACTION_TIMER_EN
  logic        react_btn;
  logic [15:0] react_time;
  logic        react_valid;
`endif

  always #5 clk = ~clk;

  f1_start_ctrl #(.PRE_W(16), .DLY_BITS(4)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .n(n),
    .cmd_seq(cmd_seq), .cmd_delay(cmd_delay),
`ifdef F1_REACTION_TIMER_EN
    .react_btn(react_btn), .react_time(react_time), .react_valid(react_valid),
`endif
    .fsm_en(fsm_en), .fsm_trigger(fsm_trigger), .busy(busy),
    .lights_out(lights_out), .delay_ticks(delay_ticks)
  );

  typedef struct {int cyc; bit trig; bit en; bit lo;} ev_t;
  ev_t q[$];

  int nchk = 0, nerr = 0;
  int cyc = 0;
  logic [6:0] mlfsr;
  int lst;
  int exp_e, exp_l, exp_d;

  function automatic logic [6:0] lfsr_adv(input logic [6:0] v, input int k);
    for (int i = 0; i < k; i++) v = {v[5:0], v[6] ^ v[5]};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle counter, reference LFSR and a light-FSM model (S1..S7 then all-on).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mlfsr <= rst ? 7'h01 : lfsr_adv(mlfsr, 1);
    if (rst) lst <= 0;
    else if (fsm_trigger && fsm_en) lst <= 1;
    else if (fsm_en) lst <= (lst >= 8 || lst == 0) ? 0 : lst + 1;
  end
  assign cmd_seq   = (lst >= 1 && lst <= 7);
  assign cmd_delay = (lst == 8);

  // Monitor: every output pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && (fsm_en || fsm_trigger || lights_out)) begin
      if (q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_event: cycle %0d en=%b trig=%b lo=%b, expected none",
                 cyc, fsm_en, fsm_trigger, lights_out);
      end else begin
        ev_t e;
        e = q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("event_trig", fsm_trigger, e.trig);
        check("event_en", fsm_en, e.en);
        check("event_lo", lights_out, e.lo);
      end
    end
  end

  task automatic step(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic step_to(input int t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask

  // Raise trigger this cycle and queue the whole expected pulse train for tick period nv+1.
  task automatic start_run(input int nv);
    int t0;
    logic [6:0] v;
    n = 16'(nv);
    trigger = 1'b1;
    t0 = cyc;
    q.push_back('{t0, 1'b1, 1'b1, 1'b0});
    for (int k = 1; k <= 7; k++) q.push_back('{t0 + k * (nv + 1), 1'b0, 1'b1, 1'b0});
    exp_e = t0 + 7 * (nv + 1) + 1;
    v = lfsr_adv(mlfsr, exp_e - t0);
    exp_d = int'(v[3:0]) + 1;
    exp_l = exp_e + exp_d * (nv + 1);
    q.push_back('{exp_l, 1'b0, 1'b1, 1'b1});
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin @(posedge clk); #1; k++; end
    check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; trigger = 1'b1; n = 16'd3;
`ifdef F1_REACTION_TIMER_EN
    react_btn = 1'b0;
`endif
    @(posedge clk); #1;
    step(2);
    check("reset_outputs", {fsm_en, fsm_trigger, busy, lights_out}, 0);
    check("reset_delay_ticks", delay_ticks, 0);
    rst = 1'b0;
    check("post_reset_outputs", {fsm_en, fsm_trigger, busy, lights_out}, 0);
    step(10);
    check("held_trigger_no_start", busy, 0);
    trigger = 1'b0;
    step(2);

    // Run A: n=3, with a trigger re-rise mid-sequence that must be ignored.
    start_run(3);
    step(6); trigger = 1'b0;
    step(2); trigger = 1'b1;
    step_to(exp_e + 1);
    check("run_a_delay_ticks", delay_ticks, exp_d);
`ifdef F1_REACTION_TIMER_EN
    react_btn = 1'b1; step(1); react_btn = 1'b0;
`endif
    wait_drain(300);
    check("run_a_busy_after_lo", busy, 1);
`ifdef F1_REACTION_TIMER_EN
    check("react_ignored_before_lo", react_valid, 0);
`endif
    step_to(exp_l + 5);
    check("run_a_rearm_busy", busy, 1);
    check("run_a_delay_ticks_stable", delay_ticks, exp_d);
`ifdef F1_REACTION_TIMER_EN
    step_to(exp_l + 250);
    react_btn = 1'b1;
    step(1);
    check("react_time", react_time, 250);
    check("react_valid", react_valid, 1);
    react_btn = 1'b0;
`endif
    trigger = 1'b0;
    step(2);
    check("rearm_exit_idle", busy, 0);

    // Run B: n=0 gives fsm_en on seven consecutive cycles.
    start_run(0);
    step(1);
    check("run_b_busy", busy, 1);
`ifdef F1_REACTION_TIMER_EN
    check("react_valid_cleared", react_valid, 0);
`endif
    step_to(exp_e + 1);
    check("run_b_delay_range", (delay_ticks >= 1 && delay_ticks <= 16), 1);
    check("run_b_delay_ticks", delay_ticks, exp_d);
    wait_drain(100);
    trigger = 1'b0;
    step(3);

    // Run C: reset while in DELAY abandons the sequence.
    start_run(3);
    step_to(exp_e + 3);
    check("run_c_in_delay", busy, 1);
    rst = 1'b1;
    q.delete();
    step(1);
    check("rst_mid_outputs", {fsm_en, fsm_trigger, busy, lights_out}, 0);
    rst = 1'b0;
    check("after_rst_outputs", {fsm_en, fsm_trigger, busy, lights_out}, 0);
    check("after_rst_delay_ticks", delay_ticks, 0);
    step(4);
    check("after_rst_idle", busy, 0);
    trigger = 1'b0;
    step(2);

    // Run D: n=1; delay value relies on the LFSR having restarted from 7'h01.
    start_run(1);
    step_to(exp_e + 1);
    check("run_d_delay_ticks", delay_ticks, exp_d);
    wait_drain(200);
    trigger = 1'b0;
    step(3);
    check("final_idle", busy, 0);
    check("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
